// File: rtl/chacha_pkg.sv
// Shared types and widths for the ChaCha20 block sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package chacha_pkg;

   localparam int KEY_W    = 256;
   localparam int NONCE_W  = 64;
   localparam int CTR_W    = 64;
   localparam int BLK_BITS = 512;

   localparam logic ENCRYP = 1'b0;
   localparam logic DECRYP = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      CORE_REQ,
      CORE_WAIT,
      DIV_ISSUE,
      DIV_WAIT,
      NEXT,
      FINISH,
      DRAIN
   } sched_state_t;

   // States in which the sequencer is waiting on an external handshake.
   function automatic logic is_wait_state(input sched_state_t s);
      return (s == CORE_WAIT) || (s == DIV_WAIT) || (s == DRAIN);
   endfunction

endpackage

// File: rtl/chunk_sched_watchdog.sv
// sched_watchdog: counts enabled cycles since the last clear and flags expiry.
// Latency: expired asserts combinationally in the TIMEOUT-th enabled cycle after a clear.
// Backpressure: none; the counter saturates at TIMEOUT-1 while enabled.
module sched_watchdog
   import chacha_pkg::*;
#(
   parameter int TIMEOUT = 4096
) (
   input  logic chunk_sched_clk,
   input  logic chunk_sched_reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt;

   assign expired = enable && (cnt == CW'(TIMEOUT - 1));

   // Cycle counter: restart on clear, advance while enabled until expiry.
   always_ff @(posedge chunk_sched_clk or negedge chunk_sched_reset_n) begin
      if (!chunk_sched_reset_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable && !expired) begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/chunk_sched.sv
// chunk_sched: runs a multi-block ChaCha20 job through the cipher core and chunk divider.
// Latency: core_start at start+1, div_valid at core_done+1, next core_start at div_last_byte+2, done one cycle after FINISH.
// Backpressure: stalls on core_done / div_last_byte; either stall longer than TIMEOUT cycles ends the job with error.
module chunk_sched
   import chacha_pkg::*;
#(
   parameter int BLK_W   = 16,
   parameter int TIMEOUT = 4096
) (
   input  logic                chunk_sched_clk,
   input  logic                chunk_sched_reset_n,
   input  logic                start,
   input  logic                abort,
   input  logic                mode,
   input  logic [BLK_W-1:0]    num_blocks,
   input  logic [CTR_W-1:0]    init_counter,
   input  logic [KEY_W-1:0]    public_key,
   input  logic [NONCE_W-1:0]  nonce,
   output logic                core_start,
   output logic [CTR_W-1:0]    core_counter,
   input  logic                core_done,
   input  logic [BLK_BITS-1:0] core_data,
   output logic                div_valid,
   output logic                div_mode,
   output logic [BLK_BITS-1:0] div_data,
   output logic [KEY_W-1:0]    div_key,
   output logic [NONCE_W-1:0]  div_nonce,
   output logic [CTR_W-1:0]    div_counter,
   input  logic                div_last_byte,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic                ctr_wrap,
   output logic [BLK_W-1:0]    blocks_left
);

   sched_state_t     state;
   sched_state_t     state_nxt;
   logic             err_set;
   logic             wd_expired;
   logic [CTR_W-1:0] ctr_q;

   // Counter is shared by both consumers so they always agree on the block number.
   assign core_counter = ctr_q;
   assign div_counter  = ctr_q;

   sched_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .chunk_sched_clk     (chunk_sched_clk),
      .chunk_sched_reset_n (chunk_sched_reset_n),
      .clear               (state_nxt != state),
      .enable              (is_wait_state(state)),
      .expired             (wd_expired)
   );

   // State register.
   always_ff @(posedge chunk_sched_clk or negedge chunk_sched_reset_n) begin
      if (!chunk_sched_reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and strobe decode; abort outranks handshakes, handshakes outrank timeout.
   always_comb begin
      state_nxt  = state;
      err_set    = 1'b0;
      core_start = 1'b0;
      div_valid  = 1'b0;
      busy       = (state != IDLE);
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = (num_blocks == '0) ? FINISH : CORE_REQ;
            end
         end
         CORE_REQ: begin
            core_start = 1'b1;
            state_nxt  = abort ? IDLE : CORE_WAIT;
         end
         CORE_WAIT: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (core_done) begin
               state_nxt = DIV_ISSUE;
            end else if (wd_expired) begin
               state_nxt = IDLE;
               err_set   = 1'b1;
            end
         end
         DIV_ISSUE: begin
            // The block is handed over even when aborting, so the divider must be drained.
            div_valid = 1'b1;
            state_nxt = abort ? DRAIN : DIV_WAIT;
         end
         DIV_WAIT: begin
            if (div_last_byte) begin
               state_nxt = abort ? IDLE : NEXT;
            end else if (abort) begin
               state_nxt = DRAIN;
            end else if (wd_expired) begin
               state_nxt = IDLE;
               err_set   = 1'b1;
            end
         end
         NEXT: begin
            if (abort) begin
               state_nxt = DRAIN;
            end else if (blocks_left == BLK_W'(1)) begin
               state_nxt = FINISH;
            end else begin
               state_nxt = CORE_REQ;
            end
         end
         FINISH: begin
            state_nxt = IDLE;
         end
         DRAIN: begin
            if (div_last_byte) begin
               state_nxt = IDLE;
            end else if (wd_expired) begin
               state_nxt = IDLE;
               err_set   = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Job context: latched once at start, counter and block count advance only in NEXT.
   always_ff @(posedge chunk_sched_clk or negedge chunk_sched_reset_n) begin
      if (!chunk_sched_reset_n) begin
         ctr_q       <= '0;
         div_mode    <= 1'b0;
         div_key     <= '0;
         div_nonce   <= '0;
         div_data    <= '0;
         blocks_left <= '0;
         error       <= 1'b0;
         ctr_wrap    <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= (state == FINISH);
         if (err_set) begin
            error <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  ctr_q       <= init_counter;
                  div_mode    <= mode;
                  div_key     <= public_key;
                  div_nonce   <= nonce;
                  blocks_left <= num_blocks;
                  error       <= 1'b0;
                  ctr_wrap    <= 1'b0;
               end
            end
            CORE_WAIT: begin
               if (core_done && !abort) begin
                  div_data <= core_data;
               end
            end
            NEXT: begin
               ctr_q       <= ctr_q + 64'd1;
               blocks_left <= blocks_left - BLK_W'(1);
               if (ctr_q == '1) begin
                  ctr_wrap <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_chunk_sched.sv
// tb_chunk_sched: scoreboard bench for chunk_sched with core and divider response models.
// Latency: n/a.
// Backpressure: models answer core_start / div_valid after programmable delays (0 = never).
module tb_chunk_sched;
   import chacha_pkg::*;

   localparam int BLK_W = 16;

   logic                chunk_sched_clk     = 1'b0;
   logic                chunk_sched_reset_n = 1'b0;
   logic                start = 1'b0;
   logic                abort = 1'b0;
   logic                mode  = 1'b0;
   logic [BLK_W-1:0]    num_blocks    = '0;
   logic [CTR_W-1:0]    init_counter  = '0;
   logic [KEY_W-1:0]    public_key    = '0;
   logic [NONCE_W-1:0]  nonce         = '0;
   logic                core_done     = 1'b0;
   logic [BLK_BITS-1:0] core_data     = '0;
   logic                div_last_byte = 1'b0;

   logic                core_start, div_valid, div_mode, busy, done, error, ctr_wrap;
   logic [CTR_W-1:0]    core_counter, div_counter;
   logic [BLK_BITS-1:0] div_data;
   logic [KEY_W-1:0]    div_key;
   logic [NONCE_W-1:0]  div_nonce;
   logic [BLK_W-1:0]    blocks_left;

   // Second instance with a short timeout; its core and divider never answer.
   logic                start2 = 1'b0;
   logic                quiet  = 1'b0;
   logic                t_core_start, t_div_valid, t_div_mode, t_busy, t_done, t_error, t_ctr_wrap;
   logic [CTR_W-1:0]    t_core_counter, t_div_counter;
   logic [BLK_BITS-1:0] t_div_data;
   logic [KEY_W-1:0]    t_div_key;
   logic [NONCE_W-1:0]  t_div_nonce;
   logic [BLK_W-1:0]    t_blocks_left;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int core_dly = 0;
   int div_dly  = 0;
   int core_tmr = 0;
   int div_tmr  = 0;
   int last_done_cyc = -100;
   int last_lb_cyc   = -100;

   logic [CTR_W-1:0]    exp_ctr_q[$];
   logic [BLK_BITS-1:0] exp_dat_q[$];
   logic [BLK_W-1:0]    exp_bl_q[$];

   chunk_sched #(.BLK_W(BLK_W), .TIMEOUT(64)) dut (
      .chunk_sched_clk(chunk_sched_clk), .chunk_sched_reset_n(chunk_sched_reset_n),
      .start(start), .abort(abort), .mode(mode), .num_blocks(num_blocks),
      .init_counter(init_counter), .public_key(public_key), .nonce(nonce),
      .core_start(core_start), .core_counter(core_counter), .core_done(core_done),
      .core_data(core_data), .div_valid(div_valid), .div_mode(div_mode),
      .div_data(div_data), .div_key(div_key), .div_nonce(div_nonce),
      .div_counter(div_counter), .div_last_byte(div_last_byte), .busy(busy),
      .done(done), .error(error), .ctr_wrap(ctr_wrap), .blocks_left(blocks_left)
   );

   chunk_sched #(.BLK_W(BLK_W), .TIMEOUT(16)) dut_to (
      .chunk_sched_clk(chunk_sched_clk), .chunk_sched_reset_n(chunk_sched_reset_n),
      .start(start2), .abort(quiet), .mode(mode), .num_blocks(num_blocks),
      .init_counter(init_counter), .public_key(public_key), .nonce(nonce),
      .core_start(t_core_start), .core_counter(t_core_counter), .core_done(quiet),
      .core_data(core_data), .div_valid(t_div_valid), .div_mode(t_div_mode),
      .div_data(t_div_data), .div_key(t_div_key), .div_nonce(t_div_nonce),
      .div_counter(t_div_counter), .div_last_byte(quiet), .busy(t_busy),
      .done(t_done), .error(t_error), .ctr_wrap(t_ctr_wrap), .blocks_left(t_blocks_left)
   );

   always #5 chunk_sched_clk = ~chunk_sched_clk;

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1, "bench time limit reached");
   end

   function automatic logic [BLK_BITS-1:0] blk_pattern(input logic [CTR_W-1:0] c);
      return {c, ~c, c ^ 64'h0F0F_0F0F_0F0F_0F0F, c + 64'd3,
              {4{c[31:0] ^ 32'hC3A5_5A3C}}, {2{c}}};
   endfunction

   // Advance to the next falling edge, end one-cycle pulses and run the core/divider models.
   task automatic tick();
      @(negedge chunk_sched_clk);
      cyc++;
      start = 1'b0; abort = 1'b0; start2 = 1'b0;
      core_done = 1'b0; div_last_byte = 1'b0;
      if (core_tmr > 0) begin
         core_tmr--;
         if (core_tmr == 0) begin
            core_done = 1'b1;
            core_data = blk_pattern(core_counter);
            exp_dat_q.push_back(core_data);
            last_done_cyc = cyc;
         end
      end
      if (core_start && core_dly > 0) core_tmr = core_dly;
      if (div_tmr > 0) begin
         div_tmr--;
         if (div_tmr == 0) begin
            div_last_byte = 1'b1;
            last_lb_cyc = cyc;
         end
      end
      if (div_valid && div_dly > 0) div_tmr = div_dly;
   endtask

   task automatic test_reset();
      chunk_sched_reset_n = 1'b0;
      repeat (3) tick();
      n_assert++;
      if ({busy, done, error, ctr_wrap, core_start, div_valid, div_mode} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected 0000000", {busy, done, error, ctr_wrap, core_start, div_valid, div_mode});
      end
      n_assert++;
      if (blocks_left !== '0 || core_counter !== '0 || div_counter !== '0) begin
         n_fail++;
         $display("FAIL reset_counts: blocks_left %0h counter %0h/%0h expected 0", blocks_left, core_counter, div_counter);
      end
      n_assert++;
      if ((|div_data) !== 1'b0 || (|div_key) !== 1'b0 || (|div_nonce) !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_context: data/key/nonce nonzero, expected all 0");
      end
      n_assert++;
      if ({t_busy, t_error, t_done} !== 3'b0) begin
         n_fail++;
         $display("FAIL reset_second: got %b expected 000", {t_busy, t_error, t_done});
      end
      chunk_sched_reset_n = 1'b1;
      tick();
   endtask

   task automatic test_encrypt();
      int s, n_cs, n_dv, done_cyc;
      logic [BLK_W-1:0]    prev_bl, e16;
      logic [CTR_W-1:0]    e64;
      logic [BLK_BITS-1:0] e512;
      mode = ENCRYP; num_blocks = 16'd3; init_counter = 64'd5;
      public_key = {8{32'hDEAD_BEEF}}; nonce = 64'h1122_3344_5566_7788;
      core_dly = 10; div_dly = 30;
      for (int k = 0; k < 3; k++) exp_ctr_q.push_back(64'd5 + 64'(k));
      exp_bl_q = '{16'd3, 16'd2, 16'd1, 16'd0};
      tick(); start = 1'b1; s = cyc;
      prev_bl = blocks_left; n_cs = 0; n_dv = 0; done_cyc = -1;
      for (int i = 0; i < 600 && done_cyc < 0; i++) begin
         tick();
         if (blocks_left !== prev_bl) begin
            prev_bl = blocks_left;
            n_assert++;
            e16 = (exp_bl_q.size() > 0) ? exp_bl_q.pop_front() : 16'hFFFF;
            if (blocks_left !== e16) begin
               n_fail++;
               $display("FAIL enc_blocks_left: got %0d expected %0d", blocks_left, e16);
            end
         end
         if (core_start) begin
            n_cs++;
            n_assert++;
            if (cyc !== ((n_cs == 1) ? s + 1 : last_lb_cyc + 2)) begin
               n_fail++;
               $display("FAIL enc_core_start_time: block %0d at cycle %0d (start %0d, last_byte %0d)", n_cs, cyc, s, last_lb_cyc);
            end
            n_assert++;
            e64 = (exp_ctr_q.size() > 0) ? exp_ctr_q.pop_front() : 64'hDEAD;
            if (core_counter !== e64 || div_counter !== e64) begin
               n_fail++;
               $display("FAIL enc_counter: got %0h/%0h expected %0h", core_counter, div_counter, e64);
            end
         end
         if (div_valid) begin
            n_dv++;
            n_assert++;
            if (cyc !== last_done_cyc + 1) begin
               n_fail++;
               $display("FAIL enc_div_valid_time: cycle %0d expected %0d", cyc, last_done_cyc + 1);
            end
            n_assert++;
            e512 = (exp_dat_q.size() > 0) ? exp_dat_q.pop_front() : '0;
            if (div_data !== e512 || div_mode !== ENCRYP || div_key !== public_key || div_nonce !== nonce) begin
               n_fail++;
               $display("FAIL enc_div_payload: data %0h mode %b expected data %0h mode 0", div_data[63:0], div_mode, e512[63:0]);
            end
         end
         if (done) done_cyc = cyc;
      end
      // done is registered off FINISH: NEXT, FINISH, then done.
      n_assert++;
      if (done_cyc !== last_lb_cyc + 3) begin
         n_fail++;
         $display("FAIL enc_done_time: got cycle %0d expected %0d", done_cyc, last_lb_cyc + 3);
      end
      n_assert++;
      if (n_cs !== 3 || n_dv !== 3 || exp_ctr_q.size() !== 0 || exp_dat_q.size() !== 0 || exp_bl_q.size() !== 0) begin
         n_fail++;
         $display("FAIL enc_counts: core_start %0d div_valid %0d expected 3/3, leftover %0d/%0d/%0d",
                  n_cs, n_dv, exp_ctr_q.size(), exp_dat_q.size(), exp_bl_q.size());
      end
   endtask

   task automatic test_zero_blocks();
      int s, n_cs, n_dv, n_busy, done_cyc;
      num_blocks = '0; init_counter = 64'd9;
      tick(); start = 1'b1; s = cyc;
      n_cs = 0; n_dv = 0; n_busy = 0; done_cyc = -1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (core_start) n_cs++;
         if (div_valid) n_dv++;
         if (busy) n_busy++;
         if (done) done_cyc = cyc;
      end
      n_assert++;
      if (n_cs !== 0 || n_dv !== 0 || n_busy !== 1) begin
         n_fail++;
         $display("FAIL zero_activity: core_start %0d div_valid %0d busy %0d expected 0/0/1", n_cs, n_dv, n_busy);
      end
      n_assert++;
      if (done_cyc !== s + 2) begin
         n_fail++;
         $display("FAIL zero_done_time: got cycle %0d expected %0d", done_cyc, s + 2);
      end
   endtask

   task automatic test_wrap();
      int n_cs, done_cyc;
      logic [CTR_W-1:0] e64;
      mode = ENCRYP; num_blocks = 16'd2; init_counter = '1;
      core_dly = 4; div_dly = 3;
      exp_ctr_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
      exp_ctr_q.push_back(64'h0);
      tick(); start = 1'b1;
      n_cs = 0; done_cyc = -1;
      for (int i = 0; i < 200 && done_cyc < 0; i++) begin
         tick();
         if (core_start) begin
            n_cs++;
            n_assert++;
            e64 = (exp_ctr_q.size() > 0) ? exp_ctr_q.pop_front() : 64'hDEAD;
            if (core_counter !== e64) begin
               n_fail++;
               $display("FAIL wrap_counter: got %0h expected %0h", core_counter, e64);
            end
            n_assert++;
            if (ctr_wrap !== (n_cs >= 2)) begin
               n_fail++;
               $display("FAIL wrap_flag_at_block: block %0d ctr_wrap %b expected %b", n_cs, ctr_wrap, n_cs >= 2);
            end
         end
         if (done) done_cyc = cyc;
      end
      repeat (5) tick();
      n_assert++;
      if (done_cyc < 0 || n_cs !== 2 || ctr_wrap !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_sticky: done %0d blocks %0d ctr_wrap %b expected done, 2 blocks, 1", done_cyc, n_cs, ctr_wrap);
      end
   endtask

   task automatic test_abort_drain();
      int s, n_cs, n_dv, dv_cyc, end_cyc, mode_bad, n_late;
      logic saw_done;
      logic [CTR_W-1:0] e64;
      mode = DECRYP; num_blocks = 16'd4; init_counter = 64'd100;
      core_dly = 10; div_dly = 30;
      exp_ctr_q.push_back(64'd100);
      tick(); start = 1'b1; s = cyc;
      n_cs = 0; n_dv = 0; dv_cyc = -100; end_cyc = -1; mode_bad = 0; saw_done = 1'b0;
      for (int i = 0; i < 300 && end_cyc < 0; i++) begin
         tick();
         if (cyc == s + 1) begin
            n_assert++;
            if (ctr_wrap !== 1'b0) begin
               n_fail++;
               $display("FAIL abort_wrap_cleared: ctr_wrap %b expected 0", ctr_wrap);
            end
         end
         if (busy && div_mode !== DECRYP) mode_bad++;
         if (done) saw_done = 1'b1;
         if (core_start) begin
            n_cs++;
            if (n_cs == 1) begin
               n_assert++;
               e64 = (exp_ctr_q.size() > 0) ? exp_ctr_q.pop_front() : 64'hDEAD;
               if (core_counter !== e64) begin
                  n_fail++;
                  $display("FAIL abort_counter: got %0h expected %0h", core_counter, e64);
               end
            end
         end
         if (div_valid) begin
            n_dv++;
            dv_cyc = cyc;
         end
         if (cyc > s && !busy) end_cyc = cyc;
         if (n_dv == 1 && cyc == dv_cyc + 5) abort = 1'b1;
      end
      n_late = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (core_start || div_valid) n_late++;
         if (done) saw_done = 1'b1;
      end
      n_assert++;
      if (end_cyc !== last_lb_cyc + 1 || last_lb_cyc !== dv_cyc + 30) begin
         n_fail++;
         $display("FAIL abort_idle_time: idle at %0d last_byte %0d div_valid %0d expected idle at last_byte+1", end_cyc, last_lb_cyc, dv_cyc);
      end
      n_assert++;
      if (n_cs !== 1 || n_dv !== 1 || n_late !== 0 || saw_done !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_activity: core_start %0d div_valid %0d late %0d done %b expected 1/1/0/0", n_cs, n_dv, n_late, saw_done);
      end
      n_assert++;
      if (mode_bad !== 0 || error !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_mode_hold: div_mode wrong in %0d busy cycles, error %b expected 0/0", mode_bad, error);
      end
   endtask

   task automatic test_timeout();
      int s, end_cyc;
      logic saw_done;
      num_blocks = 16'd2; init_counter = 64'd1;
      tick(); start2 = 1'b1; s = cyc;
      end_cyc = -1; saw_done = 1'b0;
      for (int i = 0; i < 80 && end_cyc < 0; i++) begin
         tick();
         if (cyc == s + 17) begin
            n_assert++;
            if (t_busy !== 1'b1 || t_error !== 1'b0) begin
               n_fail++;
               $display("FAIL timeout_early: busy %b error %b expected 1/0 one cycle before expiry", t_busy, t_error);
            end
         end
         if (t_done) saw_done = 1'b1;
         if (cyc > s + 1 && !t_busy) end_cyc = cyc;
      end
      n_assert++;
      if (end_cyc !== s + 18 || t_error !== 1'b1 || saw_done !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_expiry: idle at %0d error %b done %b expected %0d/1/0", end_cyc, t_error, saw_done, s + 18);
      end
      tick(); start2 = 1'b1;
      tick();
      n_assert++;
      if (t_error !== 1'b0 || t_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_restart: error %b busy %b expected 0/1", t_error, t_busy);
      end
   endtask

   task automatic test_async_reset();
      int n_cs, n_dv, done_cyc;
      logic [CTR_W-1:0]    e64;
      logic [BLK_BITS-1:0] e512;
      mode = DECRYP; num_blocks = 16'd2; init_counter = 64'd77;
      core_dly = 0; div_dly = 0;
      tick(); start = 1'b1;
      repeat (3) tick();
      n_assert++;
      if (busy !== 1'b1 || blocks_left !== 16'd2) begin
         n_fail++;
         $display("FAIL arst_precondition: busy %b blocks_left %0d expected 1/2", busy, blocks_left);
      end
      #2 chunk_sched_reset_n = 1'b0;
      #1;
      n_assert++;
      if ({busy, done, error, ctr_wrap, core_start, div_valid, div_mode} !== 7'b0 ||
          blocks_left !== '0 || core_counter !== '0 || (|div_key) !== 1'b0) begin
         n_fail++;
         $display("FAIL arst_outputs: flags %b blocks_left %0d counter %0h expected all 0",
                  {busy, done, error, ctr_wrap, core_start, div_valid, div_mode}, blocks_left, core_counter);
      end
      tick();
      chunk_sched_reset_n = 1'b1;
      core_tmr = 0; div_tmr = 0; core_dly = 5; div_dly = 3;
      exp_ctr_q.delete(); exp_dat_q.delete();
      mode = ENCRYP; num_blocks = 16'd1; init_counter = 64'd200;
      exp_ctr_q.push_back(64'd200);
      tick(); start = 1'b1;
      n_cs = 0; n_dv = 0; done_cyc = -1;
      for (int i = 0; i < 100 && done_cyc < 0; i++) begin
         tick();
         if (core_start) begin
            n_cs++;
            n_assert++;
            e64 = (exp_ctr_q.size() > 0) ? exp_ctr_q.pop_front() : 64'hDEAD;
            if (core_counter !== e64) begin
               n_fail++;
               $display("FAIL arst_job_counter: got %0h expected %0h", core_counter, e64);
            end
         end
         if (div_valid) begin
            n_dv++;
            n_assert++;
            e512 = (exp_dat_q.size() > 0) ? exp_dat_q.pop_front() : '0;
            if (div_data !== e512 || div_mode !== ENCRYP) begin
               n_fail++;
               $display("FAIL arst_job_payload: data %0h mode %b expected %0h/0", div_data[63:0], div_mode, e512[63:0]);
            end
         end
         if (done) done_cyc = cyc;
      end
      n_assert++;
      if (done_cyc < 0 || n_cs !== 1 || n_dv !== 1 || error !== 1'b0 || blocks_left !== '0) begin
         n_fail++;
         $display("FAIL arst_job_complete: done %0d core_start %0d div_valid %0d error %b blocks_left %0d",
                  done_cyc, n_cs, n_dv, error, blocks_left);
      end
   endtask

   initial begin
      test_reset();
      test_encrypt();
      test_zero_blocks();
      test_wrap();
      test_abort_drain();
      test_timeout();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
